sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port, fixed-latency external SRAM between two requesters: the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each SRAM access: address/control drive, wait states, read capture, one-cycle ready pulse.
- Generates `mem_freeze` so the pipeline holds while a data access is outstanding.
- Sits between `IF_stage`/`MEM_stage` and the board SRAM pins.

Parameters:
- BIT_NUMBER, 32: data and address width of the requester ports.
- ADDR_BITS, 18: SRAM word-address width.
- WAIT_CYCLES, 4: SRAM access time in clk cycles. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_req  input  1  instruction fetch request; held until inst_ready.
- inst_addr  input  BIT_NUMBER  byte address of the fetch.
- inst_ready  output  1  one-cycle pulse; inst_rdata valid in the same cycle.
- inst_rdata  output  BIT_NUMBER  fetched word.
- data_r_en  input  1  load request; held until data_ready.
- data_w_en  input  1  store request; held until data_ready.
- data_addr  input  BIT_NUMBER  byte address of the load/store.
- data_wdata  input  BIT_NUMBER  store data.
- data_ready  output  1  one-cycle pulse marking completion of a load/store.
- data_rdata  output  BIT_NUMBER  load data, valid with data_ready.
- mem_freeze  output  1  combinational: (data_r_en|data_w_en) & ~data_ready.
- sram_addr  output  ADDR_BITS  SRAM word address.
- sram_we_n  output  1  SRAM write enable, active-low.
- sram_oe_n  output  1  SRAM output enable, active-low.
- sram_dq_out  output  BIT_NUMBER  write data to the pad.
- sram_dq_oe  output  1  pad output-enable, active-high.
- sram_dq_in  input  BIT_NUMBER  read data from the pad.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst=0): state=IDLE, last_grant=INST (so data wins the first tie).
  - All registered outputs take their reset values immediately, even mid-access: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, inst_ready=0, data_ready=0, inst_rdata=0, data_rdata=0, counter=0.
- States: IDLE, ACCESS, RESP.
- IDLE (arbitration):
  - Pending set: D = data_r_en|data_w_en; I = inst_req.
  - Only one pending: grant it.
  - Both pending: grant the one not equal to last_grant (round-robin).
  - On a grant, register:
    - sram_addr = addr[ADDR_BITS+1:2];
    - op = write if data_w_en, else read (data_w_en wins if both enables are high);
    - sram_dq_out = data_wdata;
    - counter = WAIT_CYCLES-1;
    - last_grant = granted side.
  - Then go to ACCESS.
- ACCESS:
  - Drive for the whole state: write → sram_we_n=0, sram_dq_oe=1; read → sram_oe_n=0.
  - Counter decrements each cycle. At counter==0, sample sram_dq_in into the granted side's rdata register and go to RESP.
  - ACCESS lasts exactly WAIT_CYCLES cycles.
- RESP:
  - Controls deasserted (we_n=1, oe_n=1, dq_oe=0).
  - Granted side's ready=1 for this single cycle; then go to IDLE.
  - Stores leave data_rdata unchanged.
- Latency: request sampled in IDLE at edge T → ready high in cycle T+WAIT_CYCLES+1 → next grant is possible at the following edge.
  - Back-to-back pending requests are served with a gap of WAIT_CYCLES+2 cycles.
- Ready and rdata are registered; rdata holds its value until the next access of the same side.
- Requester drops its request mid-access: the access completes and ready still pulses. Address and wdata are not re-sampled after the grant.
- Simultaneous requests while busy: not granted until IDLE; round-robin is then applied.
- inst_rdata is never altered by a data access, and data_rdata never by a fetch.

Decomposition:
- Shared package holds: state enum (IDLE, ACCESS, RESP), grant encoding (GNT_INST, GNT_DATA), WAIT_CYCLES counter width constant (4 bits).
- One natural sub-module, `sram_rr_arbiter`: 2-way round-robin grant logic with the last_grant register.
- FSM, counter and SRAM drive stay in the top.

Test Plan:
- Reset mid-write: rst low during ACCESS → same cycle sram_we_n=1, dq_oe=0, busy=0; after release, the first tie grants data.
- Lone fetch: WAIT_CYCLES=4, inst_req=1 with inst_addr=0x100, SRAM model returns 0xE3A01005 → sram_addr=0x40, oe_n low for 4 cycles; inst_ready pulse at edge+5 with inst_rdata=0xE3A01005; busy low afterwards.
- Store then load to the same address: data_w_en with addr 0x408, wdata 0xDEADBEEF → we_n low 4 cycles, sram_addr=0x102; load of 0x408 returns data_rdata=0xDEADBEEF. mem_freeze is high until each data_ready.
- Contention: inst_req and data_r_en held together for 4 accesses → grant order DATA, INST, DATA, INST; each ready is a single-cycle pulse with the correct side's rdata.
- Early drop: inst_req deasserted two cycles into ACCESS → access finishes, inst_ready still pulses once, no extra access is started.
- Both enables high: data_r_en=data_w_en=1 → treated as write (we_n low, oe_n high); data_rdata unchanged.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, grant encoding, wait counter width.
// Pure declarations, no latency or flow control of its own.
package sram_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant between fetch and data, combinational grant, 0-cycle latency.
// The last_grant register only moves when the caller takes the grant; no backpressure of its own.
module sram_rr_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_inst,
  input  logic req_data,
  input  logic take,
  output logic gnt_vld,
  output logic gnt_data
);

  grant_t last_grant_q;
  grant_t last_grant_d;
  grant_t gnt_c;

  always_comb begin
    gnt_vld      = req_inst | req_data;
    gnt_c        = GNT_INST;
    last_grant_d = last_grant_q;
    if (req_inst && req_data) begin
      gnt_c = (last_grant_q == GNT_INST) ? GNT_DATA : GNT_INST;
    end else if (req_data) begin
      gnt_c = GNT_DATA;
    end
    if (take && gnt_vld) begin
      last_grant_d = gnt_c;
    end
  end

  assign gnt_data = (gnt_c == GNT_DATA);

  // Reset to INST so that data wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GNT_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one fixed-latency single-port SRAM between instruction fetch and load/store.
// Ready pulses WAIT_CYCLES+1 cycles after grant; requests are held (mem_freeze) until ready.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_BITS   = 18,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [BIT_NUMBER-1:0] inst_addr,
  output logic                  inst_ready,
  output logic [BIT_NUMBER-1:0] inst_rdata,
  input  logic                  data_r_en,
  input  logic                  data_w_en,
  input  logic [BIT_NUMBER-1:0] data_addr,
  input  logic [BIT_NUMBER-1:0] data_wdata,
  output logic                  data_ready,
  output logic [BIT_NUMBER-1:0] data_rdata,
  output logic                  mem_freeze,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic [BIT_NUMBER-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [BIT_NUMBER-1:0] sram_dq_in,
  output logic                  busy
);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  grant_t                  side_q, side_d;
  logic                    wr_q, wr_d;
  logic [ADDR_BITS-1:0]    sram_addr_q, sram_addr_d;
  logic [BIT_NUMBER-1:0]   dq_out_q, dq_out_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    inst_ready_q, inst_ready_d;
  logic                    data_ready_q, data_ready_d;
  logic [BIT_NUMBER-1:0]   inst_rdata_q, inst_rdata_d;
  logic [BIT_NUMBER-1:0]   data_rdata_q, data_rdata_d;

  logic                    data_pend;
  logic                    gnt_vld;
  logic                    gnt_data;
  logic                    arb_take;
  logic [BIT_NUMBER-1:0]   req_addr;
  logic                    addr_unused;

  assign data_pend   = data_r_en | data_w_en;
  assign req_addr    = gnt_data ? data_addr : inst_addr;
  assign addr_unused = ^req_addr;

  sram_rr_arbiter u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_inst (inst_req),
    .req_data (data_pend),
    .take     (arb_take),
    .gnt_vld  (gnt_vld),
    .gnt_data (gnt_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    side_d       = side_q;
    wr_d         = wr_q;
    sram_addr_d  = sram_addr_q;
    dq_out_d     = dq_out_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    dq_oe_d      = dq_oe_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    arb_take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          arb_take    = 1'b1;
          side_d      = gnt_data ? GNT_DATA : GNT_INST;
          // A store beats a load when both enables are raised.
          wr_d        = gnt_data & data_w_en;
          sram_addr_d = req_addr[ADDR_BITS+1:2];
          dq_out_d    = data_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES - 1);
          we_n_d      = ~(gnt_data & data_w_en);
          oe_n_d      = gnt_data & data_w_en;
          dq_oe_d     = gnt_data & data_w_en;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (side_q == GNT_DATA) data_rdata_d = sram_dq_in;
            else                    inst_rdata_d = sram_dq_in;
          end
          inst_ready_d = (side_q == GNT_INST);
          data_ready_d = (side_q == GNT_DATA);
          we_n_d       = 1'b1;
          oe_n_d       = 1'b1;
          dq_oe_d      = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      side_q       <= GNT_INST;
      wr_q         <= 1'b0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      side_q       <= side_d;
      wr_q         <= wr_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      dq_oe_q      <= dq_oe_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_ready  = inst_ready_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_ready  = data_ready_q;
  assign data_rdata  = data_rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign busy        = (state_q != IDLE);
  assign mem_freeze  = data_pend & ~data_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM; all checks at the falling edge.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        data_r_en;
  logic        data_w_en;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        mem_freeze;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [31:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_in;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  sram_arbiter #(.BIT_NUMBER(32), .ADDR_BITS(18), .WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .data_r_en(data_r_en), .data_w_en(data_w_en),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_freeze(mem_freeze),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = !sram_oe_n ? mem[sram_addr[9:0]] : 32'h0;

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, sram_we_n, sram_oe_n, sram_dq_oe, inst_ready, data_ready} !== 6'b011000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 011000",
               {busy, sram_we_n, sram_oe_n, sram_dq_oe, inst_ready, data_ready});
    end
    checks++;
    if (sram_addr !== 18'h0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0 || sram_dq_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h irdata=%h drdata=%h dq=%h want all 0",
               sram_addr, inst_rdata, data_rdata, sram_dq_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lone_fetch;
    inst_req  = 1'b1;
    inst_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (!busy || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 18'h40 || inst_ready !== 1'b0) begin
          errors++;
          $display("FAIL fetch_access k=%0d: busy=%b oe_n=%b we_n=%b addr=%h rdy=%b want 1 0 1 040 0",
                   k, busy, sram_oe_n, sram_we_n, sram_addr, inst_ready);
        end
      end else if (k == 5) begin
        if (inst_ready !== 1'b1 || inst_rdata !== 32'hE3A01005 || sram_oe_n !== 1'b1 || data_ready !== 1'b0) begin
          errors++;
          $display("FAIL fetch_resp: rdy=%b rdata=%h oe_n=%b drdy=%b want 1 e3a01005 1 0",
                   inst_ready, inst_rdata, sram_oe_n, data_ready);
        end
        inst_req = 1'b0;
      end else begin
        if (busy !== 1'b0 || inst_ready !== 1'b0) begin
          errors++;
          $display("FAIL fetch_after: busy=%b rdy=%b want 0 0", busy, inst_ready);
        end
      end
    end
  endtask

  task automatic test_store_load;
    data_w_en  = 1'b1;
    data_addr  = 32'h408;
    data_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (mem_freeze !== 1'b1) begin
      errors++;
      $display("FAIL freeze_on_req: got %b want 1", mem_freeze);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== 18'h102 ||
            sram_dq_out !== 32'hDEADBEEF || mem_freeze !== 1'b1) begin
          errors++;
          $display("FAIL store_access k=%0d: we_n=%b dq_oe=%b oe_n=%b addr=%h dq=%h frz=%b want 0 1 1 102 deadbeef 1",
                   k, sram_we_n, sram_dq_oe, sram_oe_n, sram_addr, sram_dq_out, mem_freeze);
        end
      end else begin
        if (data_ready !== 1'b1 || mem_freeze !== 1'b0 || data_rdata !== 32'h0 || sram_dq_oe !== 1'b0) begin
          errors++;
          $display("FAIL store_resp: rdy=%b frz=%b rdata=%h dq_oe=%b want 1 0 0 0",
                   data_ready, mem_freeze, data_rdata, sram_dq_oe);
        end
      end
    end
    data_w_en = 1'b0;
    @(negedge clk);
    data_r_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || mem_freeze !== 1'b1) begin
          errors++;
          $display("FAIL load_access k=%0d: oe_n=%b we_n=%b frz=%b want 0 1 1", k, sram_oe_n, sram_we_n, mem_freeze);
        end
      end else begin
        if (data_ready !== 1'b1 || data_rdata !== 32'hDEADBEEF || inst_rdata !== 32'hE3A01005 || mem_freeze !== 1'b0) begin
          errors++;
          $display("FAIL load_resp: rdy=%b drdata=%h irdata=%h frz=%b want 1 deadbeef e3a01005 0",
                   data_ready, data_rdata, inst_rdata, mem_freeze);
        end
      end
    end
    data_r_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    data_w_en  = 1'b1;
    data_addr  = 32'h500;
    data_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: we_n=%b busy=%b want 0 1", sram_we_n, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || busy !== 1'b0 || sram_addr !== 18'h0 || inst_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_now: we_n=%b dq_oe=%b busy=%b addr=%h irdata=%h want 1 0 0 0 0",
               sram_we_n, sram_dq_oe, busy, sram_addr, inst_rdata);
    end
    data_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_contention;
    logic        exp_data [4];
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
    int          waited;
    exp_data  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_ird   = 32'h0;
    exp_drd   = 32'h0;
    inst_req  = 1'b1;
    inst_addr = 32'h40;
    data_r_en = 1'b1;
    data_addr = 32'h80;
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(inst_ready || data_ready) && waited < 20);
      if (exp_data[n]) exp_drd = 32'h22222222;
      else             exp_ird = 32'h11111111;
      checks++;
      if (waited != 5 || data_ready !== exp_data[n] || inst_ready !== !exp_data[n] ||
          data_rdata !== exp_drd || inst_rdata !== exp_ird) begin
        errors++;
        $display("FAIL contention n=%0d: wait=%0d drdy=%b irdy=%b drd=%h ird=%h want 5 %b %b %h %h",
                 n, waited, data_ready, inst_ready, data_rdata, inst_rdata,
                 exp_data[n], !exp_data[n], exp_drd, exp_ird);
      end
      if (n == 3) begin
        inst_req  = 1'b0;
        data_r_en = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (inst_ready !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL contention_pulse n=%0d: irdy=%b drdy=%b busy=%b want 0 0 0", n, inst_ready, data_ready, busy);
      end
    end
  endtask

  task automatic test_early_drop;
    inst_req  = 1'b1;
    inst_addr = 32'h104;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) inst_req = 1'b0;
      checks++;
      if (k <= 4) begin
        if (busy !== 1'b1 || sram_oe_n !== 1'b0 || sram_addr !== 18'h41) begin
          errors++;
          $display("FAIL drop_access k=%0d: busy=%b oe_n=%b addr=%h want 1 0 041", k, busy, sram_oe_n, sram_addr);
        end
      end else if (k == 5) begin
        if (inst_ready !== 1'b1 || inst_rdata !== 32'hA5A5A5A5) begin
          errors++;
          $display("FAIL drop_resp: rdy=%b rdata=%h want 1 a5a5a5a5", inst_ready, inst_rdata);
        end
      end else begin
        if (busy !== 1'b0 || inst_ready !== 1'b0 || sram_oe_n !== 1'b1) begin
          errors++;
          $display("FAIL drop_idle k=%0d: busy=%b rdy=%b oe_n=%b want 0 0 1", k, busy, inst_ready, sram_oe_n);
        end
      end
    end
  endtask

  task automatic test_both_enables;
    data_r_en  = 1'b1;
    data_w_en  = 1'b1;
    data_addr  = 32'h600;
    data_wdata = 32'hCAFEF00D;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_addr !== 18'h180) begin
          errors++;
          $display("FAIL both_access k=%0d: we_n=%b oe_n=%b addr=%h want 0 1 180", k, sram_we_n, sram_oe_n, sram_addr);
        end
      end else begin
        if (data_ready !== 1'b1 || data_rdata !== 32'h22222222) begin
          errors++;
          $display("FAIL both_resp: rdy=%b rdata=%h want 1 22222222", data_ready, data_rdata);
        end
      end
    end
    data_r_en = 1'b0;
    data_w_en = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[10'h180] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL both_written: sram word=%h want cafef00d", mem[10'h180]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h040] = 32'hE3A01005;
    mem[10'h041] = 32'hA5A5A5A5;
    mem[10'h010] = 32'h11111111;
    mem[10'h020] = 32'h22222222;
    rst        = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_r_en  = 1'b0;
    data_w_en  = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_reset_mid_write();
    test_contention();
    test_early_drop();
    test_both_enables();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
